// File: rtl/pipirima_pkg.sv
// Shared constants, FSM encoding and width helpers for the row-wise SpMM engine.
package pipirima_pkg;

  localparam logic MODE_DIAG = 1'b0;
  localparam logic MODE_RAND = 1'b1;

  // Derived widths for the default four-lane build
  localparam int unsigned DEF_NUM_IMU = 4;
  localparam int unsigned LVL         = $clog2(DEF_NUM_IMU);
  localparam int unsigned NNZ_W       = LVL + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMul    = 2'd1,
    StReduce = 2'd2,
    StOut    = 2'd3
  } state_e;

  function automatic int unsigned lvl_of(input int unsigned num_imu);
    return $clog2(num_imu);
  endfunction

  function automatic int unsigned nnz_w_of(input int unsigned num_imu);
    return $clog2(num_imu) + 1;
  endfunction

endpackage

// File: rtl/rowwise_spmm_engine_if.sv
// Row-descriptor input stream and result-row output stream of the SpMM engine.
interface rowwise_spmm_engine_if #(
  parameter int unsigned NUM_IMU = 4,
  parameter int unsigned TILE_B  = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned ACC_W   = 2 * DW + $clog2(NUM_IMU),
  parameter int unsigned ROW_W   = 16
);
  localparam int unsigned NNZ_W = $clog2(NUM_IMU) + 1;

  logic                          in_valid;
  logic                          in_ready;
  logic                          in_mode;
  logic [NNZ_W-1:0]              in_nnz;
  logic [ROW_W-1:0]              in_row_idx;
  logic [NUM_IMU*DW-1:0]         in_val;
  logic [NUM_IMU*TILE_B*DW-1:0]  in_ddm;
  logic                          out_valid;
  logic                          out_ready;
  logic [ROW_W-1:0]              out_row_idx;
  logic [TILE_B*ACC_W-1:0]       out_row;

  modport master (
    output in_valid, in_mode, in_nnz, in_row_idx, in_val, in_ddm, out_ready,
    input  in_ready, out_valid, out_row_idx, out_row
  );

  modport slave (
    input  in_valid, in_mode, in_nnz, in_row_idx, in_val, in_ddm, out_ready,
    output in_ready, out_valid, out_row_idx, out_row
  );
endinterface

// File: rtl/imu_lane.sv
// One if-mul lane: zero-skip gate plus TILE_B signed multipliers, combinational.
module imu_lane
  import pipirima_pkg::*;
#(
  parameter int unsigned TILE_B = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned ACC_W  = 18
) (
  input  logic                    active,
  input  logic signed [DW-1:0]    val,
  input  logic [TILE_B*DW-1:0]    ddm_row,
  output logic [TILE_B*ACC_W-1:0] prod,
  output logic                    is_mul,
  output logic                    is_skip
);

  assign is_mul  = active && (val != '0);
  assign is_skip = active && (val == '0);

  for (genvar j = 0; j < TILE_B; j++) begin : g_elem
    logic signed [DW-1:0]    d;
    logic signed [ACC_W-1:0] p;
    assign d = ddm_row[j*DW +: DW];
    // Operands widened first so the product keeps its full signed range
    assign p = ACC_W'(val) * ACC_W'(d);
    assign prod[j*ACC_W +: ACC_W] = is_mul ? p : '0;
  end

endmodule

// File: rtl/rowwise_spmm_engine.sv
// Row-wise sparse x dense engine: zero-skipping IMU lanes feed CBBs reduced by a CAT tree.
module rowwise_spmm_engine
  import pipirima_pkg::*;
#(
  parameter int unsigned NUM_IMU = 4,
  parameter int unsigned TILE_B  = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned ACC_W   = 2 * DW + $clog2(NUM_IMU),
  parameter int unsigned ROW_W   = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rowwise_spmm_engine_if.slave  bus,
  output logic [CNT_W-1:0]      mul_cnt,
  output logic [CNT_W-1:0]      skip_cnt,
  output logic                  err_nnz
);

  localparam int unsigned L_LVL   = lvl_of(NUM_IMU);
  localparam int unsigned L_NNZ_W = nnz_w_of(NUM_IMU);

  state_e                                   state_q, state_d;
  logic                                     mode_q, mode_d;
  logic [ROW_W-1:0]                         row_idx_q, row_idx_d;
  logic [NUM_IMU*DW-1:0]                    val_q, val_d;
  logic [NUM_IMU*TILE_B*DW-1:0]             ddm_q, ddm_d;
  logic [L_NNZ_W-1:0]                       nnz_q, nnz_d;
  logic [L_LVL-1:0]                         lvl_q, lvl_d;
  logic [NUM_IMU-1:0][TILE_B-1:0][ACC_W-1:0] cbb_q, cbb_d;
  logic [CNT_W-1:0]                         mul_cnt_q, mul_cnt_d, skip_cnt_q, skip_cnt_d;
  logic                                     err_q, err_d;

  logic [NUM_IMU-1:0]                       active, is_mul, is_skip;
  logic [NUM_IMU-1:0][TILE_B*ACC_W-1:0]     prod;

  for (genvar i = 0; i < NUM_IMU; i++) begin : g_lane
    assign active[i] = (nnz_q > L_NNZ_W'(i));
    imu_lane #(.TILE_B(TILE_B), .DW(DW), .ACC_W(ACC_W)) u_lane (
      .active  (active[i]),
      .val     (val_q[i*DW +: DW]),
      .ddm_row (ddm_q[i*TILE_B*DW +: TILE_B*DW]),
      .prod    (prod[i]),
      .is_mul  (is_mul[i]),
      .is_skip (is_skip[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      mode_q     <= MODE_DIAG;
      row_idx_q  <= '0;
      val_q      <= '0;
      ddm_q      <= '0;
      nnz_q      <= '0;
      lvl_q      <= '0;
      cbb_q      <= '0;
      mul_cnt_q  <= '0;
      skip_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      row_idx_q  <= row_idx_d;
      val_q      <= val_d;
      ddm_q      <= ddm_d;
      nnz_q      <= nnz_d;
      lvl_q      <= lvl_d;
      cbb_q      <= cbb_d;
      mul_cnt_q  <= mul_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    logic [L_NNZ_W-1:0] clamp;
    logic [L_NNZ_W-1:0] n_mul, n_skip;
    logic [CNT_W:0]     mul_sum, skip_sum;
    state_d    = state_q;
    mode_d     = mode_q;
    row_idx_d  = row_idx_q;
    val_d      = val_q;
    ddm_d      = ddm_q;
    nnz_d      = nnz_q;
    lvl_d      = lvl_q;
    cbb_d      = cbb_q;
    mul_cnt_d  = mul_cnt_q;
    skip_cnt_d = skip_cnt_q;
    err_d      = err_q;
    clamp      = (bus.in_mode == MODE_DIAG) ? L_NNZ_W'(1) : L_NNZ_W'(NUM_IMU);
    n_mul      = '0;
    n_skip     = '0;
    for (int i = 0; i < NUM_IMU; i++) begin
      n_mul  = n_mul + L_NNZ_W'(is_mul[i]);
      n_skip = n_skip + L_NNZ_W'(is_skip[i]);
    end
    mul_sum  = {1'b0, mul_cnt_q} + (CNT_W + 1)'(n_mul);
    skip_sum = {1'b0, skip_cnt_q} + (CNT_W + 1)'(n_skip);

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          mode_d    = bus.in_mode;
          row_idx_d = bus.in_row_idx;
          val_d     = bus.in_val;
          ddm_d     = bus.in_ddm;
          nnz_d     = (bus.in_nnz > clamp) ? clamp : bus.in_nnz;
          err_d     = err_q | (bus.in_nnz > clamp);
          state_d   = StMul;
        end
      end
      StMul: begin
        for (int i = 0; i < NUM_IMU; i++) cbb_d[i] = prod[i];
        mul_cnt_d  = mul_sum[CNT_W] ? '1 : mul_sum[CNT_W-1:0];
        skip_cnt_d = skip_sum[CNT_W] ? '1 : skip_sum[CNT_W-1:0];
        lvl_d      = '0;
        state_d    = (mode_q == MODE_DIAG || nnz_q <= L_NNZ_W'(1)) ? StOut : StReduce;
      end
      StReduce: begin
        // Contiguous lane placement lets each level add fixed pairs, results kept low
        for (int k = 0; k < L_LVL; k++) begin
          if (lvl_q == L_LVL'(k)) begin
            for (int i = 0; i + (1 << k) < NUM_IMU; i += (2 << k)) begin
              for (int j = 0; j < TILE_B; j++) begin
                cbb_d[i][j] = cbb_q[i][j] + cbb_q[i + (1 << k)][j];
              end
            end
          end
        end
        lvl_d   = lvl_q + 1'b1;
        state_d = (lvl_q == L_LVL'(L_LVL - 1)) ? StOut : StReduce;
      end
      StOut: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StOut);
  assign bus.out_row     = cbb_q[0];
  assign bus.out_row_idx = row_idx_q;
  assign mul_cnt         = mul_cnt_q;
  assign skip_cnt        = skip_cnt_q;
  assign err_nnz         = err_q;

endmodule

// File: tb/tb_rowwise_spmm_engine.sv
// Directed self-checking bench for rowwise_spmm_engine at NUM_IMU=4, TILE_B=4, DW=8.
module tb_rowwise_spmm_engine;
  import pipirima_pkg::*;

  localparam int unsigned NI    = 4;
  localparam int unsigned TB    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned ACC_W = 18;
  localparam int unsigned ROW_W = 16;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CNT_W-1:0] mul_cnt, skip_cnt;
  logic err_nnz;

  int checks = 0;
  int errors = 0;
  int tv[NI];
  int td[NI][TB];
  int er[TB];
  int lat;
  logic signed [ACC_W-1:0] got;

  always #5 clk = ~clk;

  rowwise_spmm_engine_if #(.NUM_IMU(NI), .TILE_B(TB), .DW(DW), .ACC_W(ACC_W), .ROW_W(ROW_W)) bus();

  rowwise_spmm_engine #(
    .NUM_IMU(NI), .TILE_B(TB), .DW(DW), .ACC_W(ACC_W), .ROW_W(ROW_W), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mul_cnt  (mul_cnt),
    .skip_cnt (skip_cnt),
    .err_nnz  (err_nnz)
  );

  task automatic drive_row(input logic mode, input int nnz, input int idx);
    for (int i = 0; i < NI; i++) begin
      bus.in_val[i*DW +: DW] = DW'(tv[i]);
      for (int j = 0; j < TB; j++) bus.in_ddm[(i*TB+j)*DW +: DW] = DW'(td[i][j]);
    end
    bus.in_mode    = mode;
    bus.in_nnz     = 3'(nnz);
    bus.in_row_idx = ROW_W'(idx);
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen; -1 if it never appears
  task automatic run_row(input logic mode, input int nnz, input int idx, output int l);
    drive_row(mode, nnz, idx);
    l = 0;
    while (!bus.out_valid && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
    if (!bus.out_valid) l = -1;
  endtask

  task automatic set_ddm_rows(input int r0[TB], input int r1[TB], input int r2[TB],
                              input int r3[TB]);
    for (int j = 0; j < TB; j++) begin
      td[0][j] = r0[j]; td[1][j] = r1[j]; td[2][j] = r2[j]; td[3][j] = r3[j];
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL reset in_ready: got %0b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset out_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_row !== '0) begin errors++;
      $display("FAIL reset out_row: got %h expected 0", bus.out_row); end
    checks++; if (bus.out_row_idx !== '0) begin errors++;
      $display("FAIL reset out_row_idx: got %0d expected 0", bus.out_row_idx); end
    checks++; if (mul_cnt !== '0 || skip_cnt !== '0) begin errors++;
      $display("FAIL reset counters: got %0d/%0d expected 0/0", mul_cnt, skip_cnt); end
    checks++; if (err_nnz !== 1'b0) begin errors++;
      $display("FAIL reset err_nnz: got %0b expected 0", err_nnz); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_diag();
    tv = '{3, 5, 7, 9};
    set_ddm_rows('{1, 2, 3, 4}, '{1, 1, 1, 1}, '{2, 2, 2, 2}, '{3, 3, 3, 3});
    er = '{3, 6, 9, 12};
    run_row(MODE_DIAG, 1, 17, lat);
    // Accept at edge T, out_valid observed at edge T+2
    checks++; if (lat !== 1) begin errors++;
      $display("FAIL diag latency: got %0d expected 1", lat); end
    for (int j = 0; j < TB; j++) begin
      got = bus.out_row[j*ACC_W +: ACC_W];
      checks++; if (got !== ACC_W'(er[j])) begin errors++;
        $display("FAIL diag out_row[%0d]: got %0d expected %0d", j, got, er[j]); end
    end
    checks++; if (bus.out_row_idx !== 16'd17) begin errors++;
      $display("FAIL diag out_row_idx: got %0d expected 17", bus.out_row_idx); end
    checks++; if (mul_cnt !== 16'd1 || skip_cnt !== 16'd0) begin errors++;
      $display("FAIL diag counters: got %0d/%0d expected 1/0", mul_cnt, skip_cnt); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL diag release: got valid=%0b ready=%0b expected 0/1",
               bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_rand();
    tv = '{1, 2, 0, -1};
    set_ddm_rows('{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 9, 9, 9}, '{1, 1, 1, 1});
    er = '{10, 13, 16, 19};
    run_row(MODE_RAND, 4, 42, lat);
    checks++; if (lat !== 1 + LVL) begin errors++;
      $display("FAIL rand latency: got %0d expected %0d", lat, 1 + LVL); end
    for (int j = 0; j < TB; j++) begin
      got = bus.out_row[j*ACC_W +: ACC_W];
      checks++; if (got !== ACC_W'(er[j])) begin errors++;
        $display("FAIL rand out_row[%0d]: got %0d expected %0d", j, got, er[j]); end
    end
    checks++; if (bus.out_row_idx !== 16'd42) begin errors++;
      $display("FAIL rand out_row_idx: got %0d expected 42", bus.out_row_idx); end
    checks++; if (mul_cnt !== 16'd4 || skip_cnt !== 16'd1) begin errors++;
      $display("FAIL rand counters: got %0d/%0d expected 4/1", mul_cnt, skip_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_extremes();
    tv = '{-128, -128, -128, -128};
    set_ddm_rows('{-128, -128, -128, -128}, '{-128, -128, -128, -128},
                 '{-128, -128, -128, -128}, '{-128, -128, -128, -128});
    run_row(MODE_RAND, 4, 7, lat);
    checks++; if (lat !== 1 + LVL) begin errors++;
      $display("FAIL extreme latency: got %0d expected %0d", lat, 1 + LVL); end
    for (int j = 0; j < TB; j++) begin
      got = bus.out_row[j*ACC_W +: ACC_W];
      checks++; if (got !== 18'sd65536) begin errors++;
        $display("FAIL extreme out_row[%0d]: got %0d expected 65536", j, got); end
    end
    @(posedge clk); #1;
    run_row(MODE_RAND, 0, 8, lat);
    checks++; if (lat !== 1) begin errors++;
      $display("FAIL nnz0 latency: got %0d expected 1", lat); end
    checks++; if (bus.out_row !== '0) begin errors++;
      $display("FAIL nnz0 out_row: got %h expected 0", bus.out_row); end
    checks++; if (mul_cnt !== 16'd8 || skip_cnt !== 16'd1) begin errors++;
      $display("FAIL nnz0 counters: got %0d/%0d expected 8/1", mul_cnt, skip_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    tv = '{-2, 0, 0, 0};
    set_ddm_rows('{1, -1, 5, 7}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0});
    er = '{-2, 2, -10, -14};
    bus.out_ready = 1'b0;
    run_row(MODE_DIAG, 1, 99, lat);
    checks++; if (lat !== 1) begin errors++;
      $display("FAIL bp latency: got %0d expected 1", lat); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_row_idx !== 16'd99)
      begin errors++;
        $display("FAIL bp hold cycle %0d: got valid=%0b ready=%0b idx=%0d expected 1/0/99",
                 c, bus.out_valid, bus.in_ready, bus.out_row_idx); end
      for (int j = 0; j < TB; j++) begin
        got = bus.out_row[j*ACC_W +: ACC_W];
        checks++; if (got !== ACC_W'(er[j])) begin errors++;
          $display("FAIL bp out_row[%0d] cycle %0d: got %0d expected %0d", j, c, got, er[j]); end
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL bp release: got ready=%0b valid=%0b expected 1/0",
               bus.in_ready, bus.out_valid); end
    tv = '{2, 3, 0, 0};
    set_ddm_rows('{1, 1, 1, 1}, '{2, 2, 2, 2}, '{0, 0, 0, 0}, '{0, 0, 0, 0});
    run_row(MODE_RAND, 2, 100, lat);
    checks++; if (lat !== 1 + LVL) begin errors++;
      $display("FAIL bp next latency: got %0d expected %0d", lat, 1 + LVL); end
    for (int j = 0; j < TB; j++) begin
      got = bus.out_row[j*ACC_W +: ACC_W];
      checks++; if (got !== 18'sd8) begin errors++;
        $display("FAIL bp next out_row[%0d]: got %0d expected 8", j, got); end
    end
    checks++; if (mul_cnt !== 16'd11 || skip_cnt !== 16'd1) begin errors++;
      $display("FAIL bp counters: got %0d/%0d expected 11/1", mul_cnt, skip_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    checks++; if (err_nnz !== 1'b0) begin errors++;
      $display("FAIL err before: got %0b expected 0", err_nnz); end
    tv = '{1, 1, 1, 1};
    set_ddm_rows('{1, 2, 3, 4}, '{1, 2, 3, 4}, '{1, 2, 3, 4}, '{1, 2, 3, 4});
    er = '{4, 8, 12, 16};
    run_row(MODE_RAND, 5, 5, lat);
    for (int j = 0; j < TB; j++) begin
      got = bus.out_row[j*ACC_W +: ACC_W];
      checks++; if (got !== ACC_W'(er[j])) begin errors++;
        $display("FAIL nnz5 out_row[%0d]: got %0d expected %0d", j, got, er[j]); end
    end
    checks++; if (err_nnz !== 1'b1 || mul_cnt !== 16'd15) begin errors++;
      $display("FAIL nnz5 err/mul: got %0b/%0d expected 1/15", err_nnz, mul_cnt); end
    @(posedge clk); #1;
    tv = '{2, 5, 5, 5};
    er = '{2, 4, 6, 8};
    run_row(MODE_DIAG, 3, 6, lat);
    checks++; if (lat !== 1) begin errors++;
      $display("FAIL diag3 latency: got %0d expected 1", lat); end
    for (int j = 0; j < TB; j++) begin
      got = bus.out_row[j*ACC_W +: ACC_W];
      checks++; if (got !== ACC_W'(er[j])) begin errors++;
        $display("FAIL diag3 out_row[%0d]: got %0d expected %0d", j, got, er[j]); end
    end
    checks++; if (err_nnz !== 1'b1 || mul_cnt !== 16'd16) begin errors++;
      $display("FAIL diag3 err/mul: got %0b/%0d expected 1/16", err_nnz, mul_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    tv = '{1, 1, 1, 1};
    set_ddm_rows('{1, 1, 1, 1}, '{1, 1, 1, 1}, '{1, 1, 1, 1}, '{1, 1, 1, 1});
    drive_row(MODE_RAND, 4, 77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL midrst handshake: got valid=%0b ready=%0b expected 0/1",
               bus.out_valid, bus.in_ready); end
    checks++; if (mul_cnt !== '0 || skip_cnt !== '0 || err_nnz !== 1'b0) begin errors++;
      $display("FAIL midrst state: got mul=%0d skip=%0d err=%0b expected 0/0/0",
               mul_cnt, skip_cnt, err_nnz); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tv = '{1, -1, 2, 0};
    set_ddm_rows('{1, 2, 3, 4}, '{4, 3, 2, 1}, '{1, 1, 1, 1}, '{9, 9, 9, 9});
    er = '{-1, 1, 3, 5};
    run_row(MODE_RAND, 3, 78, lat);
    checks++; if (lat !== 1 + LVL) begin errors++;
      $display("FAIL midrst latency: got %0d expected %0d", lat, 1 + LVL); end
    for (int j = 0; j < TB; j++) begin
      got = bus.out_row[j*ACC_W +: ACC_W];
      checks++; if (got !== ACC_W'(er[j])) begin errors++;
        $display("FAIL midrst out_row[%0d]: got %0d expected %0d", j, got, er[j]); end
    end
    checks++; if (mul_cnt !== 16'd3 || skip_cnt !== 16'd0 || bus.out_row_idx !== 16'd78)
    begin errors++;
      $display("FAIL midrst counters/idx: got %0d/%0d/%0d expected 3/0/78",
               mul_cnt, skip_cnt, bus.out_row_idx); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_mode    = MODE_DIAG;
    bus.in_nnz     = '0;
    bus.in_row_idx = '0;
    bus.in_val     = '0;
    bus.in_ddm     = '0;
    bus.out_ready  = 1'b1;
    #2;
    test_reset();
    test_diag();
    test_rand();
    test_extremes();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rowwise_spmm_engine.md
Name: rowwise_spmm_engine

Overview:
- Parametrised successor of the row-wise multiplier top, built as one self-contained engine.
- Each accepted sparse row is processed in four steps: NUM_IMU if-mul lanes apply zero-skip to the row's non-zero values; each lane scales one DDM row vector of TILE_B elements; partial products land in per-lane CBBs; a CBB-based adder tree (CAT) reduces them.
- Two modes: diagonal (DSMU: single lane, no adds) and random (RSMU: multi-lane with tree reduction).
- Sits between the NNZ/row predictor / DDM fetch front-end and the output buffer.

Parameters:
- NUM_IMU, 4, number of IMU lanes and CBBs; power of 2, at least 2.
- TILE_B, 4, elements per DDM row vector (fine-grain parallelism per IMU).
- DW, 8, signed data width of values and DDM elements.
- ACC_W, 2*DW+$clog2(NUM_IMU), signed accumulator/output element width.
- ROW_W, 16, row index width.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  row descriptor valid.
- in_ready  out  1  engine can accept a row.
- in_mode  in  1  0 = DIAG (DSMU), 1 = RAND (RSMU).
- in_nnz  in  $clog2(NUM_IMU)+1  non-zeros in this row.
- in_row_idx  in  ROW_W  output row index, passed through.
- in_val  in  NUM_IMU*DW  values[i]; lane i occupies bits [i*DW +: DW].
- in_ddm  in  NUM_IMU*TILE_B*DW  DDM rows; lane i, element j occupies bits [(i*TILE_B+j)*DW +: DW].
- out_valid  out  1  output row valid.
- out_ready  in  1  output buffer accepts.
- out_row_idx  out  ROW_W  row index.
- out_row  out  TILE_B*ACC_W  result row; element j occupies bits [j*ACC_W +: ACC_W].
- mul_cnt  out  CNT_W  multiplications performed (saturating).
- skip_cnt  out  CNT_W  zero values routed to skip path (saturating).
- err_nnz  out  1  sticky: in_nnz > NUM_IMU, or DIAG mode with in_nnz > 1.

Behaviour:
- Reset (async, active-low) does all of the following:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - out_row, out_row_idx, all CBBs, mul_cnt, skip_cnt and err_nnz go to 0.
  - Applies mid-operation too: any in-flight row is dropped.
- FSM states: IDLE, MUL, REDUCE, OUT.
- in_ready = (state == IDLE). No overlap between rows.
- IDLE: on in_valid & in_ready, the engine:
  - latches mode, row_idx, val and ddm;
  - computes nnz_eff = min(in_nnz, NUM_IMU); in DIAG mode nnz_eff = min(in_nnz, 1);
  - sets err_nnz if the clamp changed the value;
  - goes to MUL.
- MUL (1 cycle): for each lane i:
  - If i < nnz_eff and val[i] != 0: CBB[i][j] = sext(val[i]*ddm[i][j]) for every j.
  - Otherwise CBB[i] = 0 and no multiply occurs.
  - Counters: mul_cnt += number of active lanes with non-zero value; skip_cnt += number of active lanes with zero value. Lanes with i >= nnz_eff count toward neither. Both counters saturate at all-ones.
  - Next state: DIAG mode, or nnz_eff <= 1, goes to OUT; otherwise REDUCE with level = 0.
- REDUCE: one tree level per cycle, L = log2(NUM_IMU) cycles.
  - At level k: CBB[i] <= CBB[i] + CBB[i + 2^k] for every i that is a multiple of 2^(k+1). The result stays in the lower CBB.
  - Element-wise over TILE_B. No index matching, because placement is contiguous.
  - After level L-1, go to OUT.
- OUT: out_valid = 1, out_row = CBB[0], out_row_idx = latched index.
  - On out_ready: return to IDLE; out_valid drops the next cycle.
  - While out_ready = 0, out_row and out_row_idx stay stable.
- Latency, with handshake at edge T:
  - DIAG, or nnz <= 1: out_valid from cycle T+2.
  - RAND with nnz >= 2: out_valid from cycle T+2+L.
- Throughput: one row per 3 (DIAG) or 3+L (RAND) cycles, with out_ready held high.
- Arithmetic: signed two's complement; products sign-extended to ACC_W; overflow is impossible by construction.
- in_nnz = 0: all lanes are masked, output is zeros, DIAG latency applies.

Decomposition:
- Shared package pipirima_pkg holds:
  - MODE_DIAG = 1'b0 and MODE_RAND = 1'b1;
  - FSM state encodings;
  - localparam helpers LVL = $clog2(NUM_IMU) and NNZ_W.
- One sub-module, imu_lane: zero-check mux plus TILE_B signed multipliers, purely combinational.
  - Inputs: active, val, ddm_row.
  - Outputs: prod vector, is_mul, is_skip.
  - Instantiated NUM_IMU times in a generate loop.
- CBB storage and the CAT tree stay in the top.

Test Plan (defaults NUM_IMU=4, TILE_B=4, DW=8; all values are signed decimal):
- DIAG row: nnz=1, val0=3, ddm0=[1,2,3,4] -> out_row=[3,6,9,12] with out_valid at T+2; mul_cnt=1, skip_cnt=0.
- RAND row: nnz=4, vals=[1,2,0,-1], ddm=[1,2,3,4]/[5,6,7,8]/[9,9,9,9]/[1,1,1,1] -> out_row=[10,13,16,19] at T+4; mul_cnt+=3, skip_cnt+=1.
- Extremes: nnz=4, all vals=-128, all ddm=-128 -> each element = 65536, no wrap (ACC_W=18); then nnz=0 -> all zeros at T+2.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid, out_row and out_row_idx stable, in_ready=0; release -> in_ready=1 on the next cycle; the next row is accepted correctly.
- Error cases: nnz=5 in RAND -> treated as 4, err_nnz=1 and sticky; DIAG with nnz=3 -> only lane 0 used, err_nnz stays 1.
- Reset mid-REDUCE: drop rst for 1 cycle -> out_valid=0, counters=0, err_nnz=0, in_ready=1 after release; the following row produces the correct result.
